// File: rtl/ct_split.sv
// ct_split: packet-aware 1-to-NO demultiplexer.
// Steers whole valid/ready/eop packets to one of NO ports. The destination is
// latched on the first beat of a packet and held through EOP. Packets whose
// destination is out of range are consumed and discarded. A two-entry skid
// buffer (main + skid) registers every output and breaks the ready path.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_data/i_valid/   input stream; o_ready is registered (= !skid_valid)
//   i_eop/i_dest      i_dest is sampled only on the first beat of a packet
//   o_ready
//   o_data/o_eop      shared output payload, meaningful while any o_valid set
//   o_valid[NO]       one-hot per-port valid
//   i_ready[NO]       per-port ready
//   o_drop            one-cycle pulse after accepting EOP of a dropped packet
module ct_split #(
  parameter int unsigned NO     = 2,
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned NOBITS = (NO > 1) ? $clog2(NO) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_eop,
  input  logic [NOBITS-1:0] i_dest,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_eop,
  output logic [NO-1:0]     o_valid,
  input  logic [NO-1:0]     i_ready,
  output logic              o_drop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t              state;
  logic [NOBITS-1:0]   cur_dest;

  // Skid entry; the main entry lives directly in o_data/o_eop/o_valid.
  logic                skid_valid;
  logic [WIDTH-1:0]    skid_data;
  logic                skid_eop;
  logic [NO-1:0]       skid_oh;

  logic                acc;
  logic                dest_ok;
  logic [NOBITS-1:0]   route_dest;
  logic [NO-1:0]       route_oh;
  logic                routed;
  logic                main_valid;
  logic                pop;

  // Accept/route/pop decode; main_valid is implied by the one-hot o_valid.
  always_comb begin
    acc        = i_valid && o_ready;
    dest_ok    = 32'(i_dest) < NO;
    route_dest = (state == FWD) ? cur_dest : i_dest;
    route_oh   = NO'(1) << route_dest;
    routed     = acc && ((state == FWD) || ((state == IDLE) && dest_ok));
    main_valid = |o_valid;
    pop        = |(o_valid & i_ready);
  end

  // Packet framing plus the two-entry output buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      o_valid    <= '0;
      skid_valid <= 1'b0;
      o_ready    <= 1'b1;
      o_drop     <= 1'b0;
    end else begin
      o_drop <= 1'b0;

      if (acc) begin
        case (state)
          IDLE: begin
            if (dest_ok) begin
              cur_dest <= i_dest;
              if (!i_eop) state <= FWD;
            end else if (i_eop) begin
              o_drop <= 1'b1;
            end else begin
              state <= DROP;
            end
          end
          FWD: begin
            if (i_eop) state <= IDLE;
          end
          DROP: begin
            if (i_eop) begin
              o_drop <= 1'b1;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // o_ready is low while skid is full, so no routed accept can coincide
      // with a skid-to-main transfer.
      if (pop && skid_valid) begin
        o_valid    <= skid_oh;
        o_data     <= skid_data;
        o_eop      <= skid_eop;
        skid_valid <= 1'b0;
        o_ready    <= 1'b1;
      end else if (routed && (!main_valid || pop)) begin
        o_valid <= route_oh;
        o_data  <= i_data;
        o_eop   <= i_eop;
      end else if (routed) begin
        skid_oh    <= route_oh;
        skid_data  <= i_data;
        skid_eop   <= i_eop;
        skid_valid <= 1'b1;
        o_ready    <= 1'b0;
      end else if (pop) begin
        o_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ct_split.sv
// Self-checking bench for ct_split (NO=4, WIDTH=8, NOBITS=3 so that
// destinations 4..7 are out of range). A behavioural model keeps the beats
// in flight as a FIFO queue and tracks packet framing with plain flags.
module tb_ct_split;

  localparam int unsigned NO     = 4;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NOBITS = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [WIDTH-1:0]  i_data;
  logic              i_valid;
  logic              o_ready;
  logic              i_eop;
  logic [NOBITS-1:0] i_dest;
  logic [WIDTH-1:0]  o_data;
  logic              o_eop;
  logic [NO-1:0]     o_valid;
  logic [NO-1:0]     i_ready;
  logic              o_drop;

  int checks   = 0;
  int failures = 0;
  int drop_seen = 0;

  ct_split #(.NO(NO), .WIDTH(WIDTH), .NOBITS(NOBITS)) dut (
    .clk(clk), .reset(reset),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_eop(i_eop), .i_dest(i_dest),
    .o_data(o_data), .o_eop(o_eop), .o_valid(o_valid),
    .i_ready(i_ready), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         port;
  } beat_t;

  beat_t q[$];
  bit    in_pkt   = 1'b0;
  bit    pkt_drop = 1'b0;
  int    pkt_port = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict accept/pop from the model, advance, then compare.
  task automatic step();
    bit         acc;
    bit         pop;
    bit         drop_exp;
    beat_t      b;
    logic [3:0] ev;
    acc      = i_valid && (q.size() < 2);
    pop      = (q.size() > 0) && i_ready[q[0].port];
    drop_exp = 1'b0;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (!in_pkt) begin
        pkt_drop = (int'(i_dest) >= int'(NO));
        pkt_port = int'(i_dest);
      end
      if (!pkt_drop) begin
        b.d = i_data; b.e = i_eop; b.port = pkt_port;
        q.push_back(b);
      end else if (i_eop) begin
        drop_exp = 1'b1;
      end
      in_pkt = !i_eop;
    end
    if (o_drop === 1'b1) drop_seen++;
    ev = '0;
    if (q.size() > 0) ev[q[0].port] = 1'b1;
    chk("o_ready", 32'(o_ready), 32'(q.size() < 2));
    chk("o_valid", 32'(o_valid), 32'(ev));
    chk("o_drop", 32'(o_drop), 32'(drop_exp));
    if (q.size() > 0) begin
      chk("o_data", 32'(o_data), 32'(q[0].d));
      chk("o_eop", 32'(o_eop), 32'(q[0].e));
    end
  endtask

  // Present one beat and hold it until the model says it was accepted.
  task automatic send(input logic [7:0] d, input logic e, input logic [2:0] dst);
    bit done;
    done    = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    i_eop   = e;
    i_dest  = dst;
    for (int n = 0; n < 200 && !done; n++) begin
      done = (q.size() < 2);
      step();
    end
    chk("send_accept", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    in_pkt   = 1'b0;
    pkt_drop = 1'b0;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_ready", 32'(o_ready), 32'd1);
    chk("rst_o_drop", 32'(o_drop), 32'd0);
  endtask

  initial begin
    int d0;
    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_eop   = 1'b0;
    i_dest  = '0;
    i_ready = 4'hF;
    repeat (2) @(posedge clk);
    do_reset();

    // Single-beat packet to port 2.
    send(8'hA5, 1'b1, 3'd2);
    chk("t1_valid", 32'(o_valid), 32'h4);
    chk("t1_data", 32'(o_data), 32'hA5);
    chk("t1_eop", 32'(o_eop), 32'd1);
    idle(2);

    // 4-beat packet: dest latched on beat 0, later i_dest ignored.
    send(8'h10, 1'b0, 3'd1);
    send(8'h11, 1'b0, 3'd3);
    send(8'h12, 1'b0, 3'd3);
    send(8'h13, 1'b1, 3'd3);
    chk("t2_valid", 32'(o_valid), 32'h2);
    chk("t2_data", 32'(o_data), 32'h13);
    chk("t2_eop", 32'(o_eop), 32'd1);
    idle(2);

    // Backpressure on port 0: only two beats fit.
    i_ready = 4'hE;
    send(8'h20, 1'b0, 3'd0);
    send(8'h21, 1'b0, 3'd0);
    i_valid = 1'b1; i_data = 8'h22; i_eop = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("t3_ready_low", 32'(o_ready), 32'd0);
    i_ready = 4'hF;
    send(8'h22, 1'b0, 3'd0);
    send(8'h23, 1'b0, 3'd0);
    send(8'h24, 1'b0, 3'd0);
    send(8'h25, 1'b1, 3'd0);
    idle(3);
    chk("t3_drained", 32'(o_valid), 32'd0);

    // Out-of-range packet followed by a good packet.
    d0 = drop_seen;
    send(8'h30, 1'b0, 3'd5);
    chk("t4_no_valid", 32'(o_valid), 32'd0);
    send(8'h31, 1'b0, 3'd1);
    send(8'h32, 1'b1, 3'd0);
    chk("t4_drop_pulse", 32'(o_drop), 32'd1);
    send(8'h40, 1'b0, 3'd0);
    send(8'h41, 1'b1, 3'd2);
    chk("t4_valid", 32'(o_valid), 32'h1);
    idle(2);
    chk("t4_drop_count", 32'(drop_seen - d0), 32'd1);

    // Reset in the middle of a packet to port 3.
    send(8'h50, 1'b0, 3'd3);
    send(8'h51, 1'b0, 3'd3);
    do_reset();
    send(8'h60, 1'b1, 3'd1);
    chk("t5_valid", 32'(o_valid), 32'h2);
    chk("t5_data", 32'(o_data), 32'h60);
    idle(2);

    // Alternating single-beat packets.
    for (int k = 0; k < 4; k++) begin
      send(8'(8'h70 + k), 1'b1, 3'(k % 2));
      chk("t6_valid", 32'(o_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("t6_ready", 32'(o_ready), 32'd1);
    end
    idle(2);

    // Randomised traffic with random per-port backpressure.
    for (int k = 0; k < 600; k++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = 8'($urandom);
      i_eop   = ($urandom_range(0, 2) == 0);
      i_dest  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7))
                                              : 3'($urandom_range(0, 3));
      i_ready = 4'($urandom);
      step();
    end
    i_ready = 4'hF;
    idle(4);
    chk("final_empty", 32'(o_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
